alu_cmd_issuer: RTL and testbench

Initiator side of the ALU function-select interface. It loads one command byte-serially from the 8-bit pin bus: opcode, then operand A, then operand B. It drives FS and operands to the ALU datapath (whose control decoder turns FS into BSEL/CISEL/OSEL/CSEL), waits a fixed latency, captures result and carry, and returns them through a valid/ready output. It sits between the Tiny Tapeout IO wrapper and the ALU datapath.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_lat_counter.sv | 35 +++
 rtl/alu_cmd_issuer.sv | 175 +++++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: encodings shared by the ALU command issuer and the ALU control
// decoder, so function-select codes and FSM states are defined only once.
//   FS_*          : 3-bit function-select encodings driven on fs
//   FS_ILLEGAL    : reserved code, flagged as an error and never driven on fs
//   state_t       : issuer FSM states S_OP, S_A, S_B, S_EX, S_RES
//   OPC_CHAIN_BIT : opcode bit that requests result chaining (ACCUM_EN builds)
package alu_pkg;

    localparam logic [2:0] FS_ADD     = 3'b000;
    localparam logic [2:0] FS_SUB     = 3'b001;
    localparam logic [2:0] FS_SRA     = 3'b010;
    localparam logic [2:0] FS_SRL     = 3'b011;
    localparam logic [2:0] FS_SLL     = 3'b100;
    localparam logic [2:0] FS_AND     = 3'b101;
    localparam logic [2:0] FS_OR      = 3'b110;
    localparam logic [2:0] FS_ILLEGAL = 3'b111;

    typedef enum logic [2:0] {
        S_OP  = 3'd0,
        S_A   = 3'd1,
        S_B   = 3'd2,
        S_EX  = 3'd3,
        S_RES = 3'd4
    } state_t;

    localparam int OPC_CHAIN_BIT = 7;

endpackage

// File: rtl/alu_lat_counter.sv
// alu_lat_counter: 3-bit down-counter timing the wait for the ALU result.
//   clk, rst  : clock and synchronous active-high reset
//   load      : load load_val (has priority over dec)
//   load_val  : value loaded on load
//   dec       : decrement by one; saturates at zero
//   zero      : count is zero
module alu_lat_counter
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [2:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [2:0] count_r;

    // Count register: load wins over decrement, never wraps below zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= 3'd0;
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != 3'd0)) begin
            count_r <= count_r - 3'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == 3'd0);

endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: initiator side of the ALU function-select interface.
// Loads opcode, A and B bytes from the loader bus, drives fs/alu_a/alu_b to
// the ALU for ALU_LAT cycles, captures alu_y/alu_c and offers the result on a
// valid/ready output. Illegal opcode 111 bypasses the ALU and reports out_err.
// Optional macro ACCUM_EN: opcode bit7=1 chains the previous result in as A
// and skips the A beat.
//   clk, rst                  : clock, synchronous active-high reset
//   in_valid/in_ready/in_data : byte-serial command loader
//   fs, alu_a, alu_b          : function select and operands to the ALU
//   alu_y, alu_c              : ALU result and carry/flag
//   out_valid/out_ready       : result handshake
//   out_data/out_carry/out_err: captured result, carry, illegal-opcode flag
//   busy                      : high in every state except S_OP
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int W       = 8,
    parameter int ALU_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    output logic [2:0]   fs,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic [W-1:0] alu_y,
    input  logic         alu_c,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_carry,
    output logic         out_err,
    output logic         busy
);

    localparam logic [2:0] LAT_LOAD = 3'(ALU_LAT - 1);

    state_t       state_r;
    logic [2:0]   op_r;
    logic         err_r;
    logic [W-1:0] a_r;
    logic         in_hs_s;
    logic         cnt_load_s;
    logic         cnt_dec_s;
    logic         cnt_zero_s;
`ifdef ACCUM_EN
    logic [W-1:0] last_r;
`endif

    assign in_hs_s    = in_valid && in_ready;
    assign cnt_load_s = (state_r == S_B) && in_hs_s && !err_r;
    assign cnt_dec_s  = (state_r == S_EX);

    alu_lat_counter u_lat (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load_s),
        .load_val (LAT_LOAD),
        .dec      (cnt_dec_s),
        .zero     (cnt_zero_s)
    );

    // Command FSM; every output is registered and updated on the transition
    // into the state that owns it, so in_ready never depends on in_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_OP;
            op_r      <= 3'b000;
            err_r     <= 1'b0;
            a_r       <= '0;
            fs        <= FS_ADD;
            alu_a     <= '0;
            alu_b     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_carry <= 1'b0;
            out_err   <= 1'b0;
            busy      <= 1'b0;
`ifdef ACCUM_EN
            last_r    <= '0;
`endif
        end else begin
            case (state_r)
                S_OP: begin
                    in_ready <= 1'b1;
                    if (in_hs_s) begin
                        op_r  <= in_data[2:0];
                        err_r <= (in_data[2:0] == FS_ILLEGAL);
                        busy  <= 1'b1;
`ifdef ACCUM_EN
                        if (in_data[OPC_CHAIN_BIT]) begin
                            a_r     <= last_r;
                            state_r <= S_B;
                        end else begin
                            state_r <= S_A;
                        end
`else
                        state_r <= S_A;
`endif
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_A: begin
                    in_ready <= 1'b1;
                    busy     <= 1'b1;
                    if (in_hs_s) begin
                        a_r     <= in_data;
                        state_r <= S_B;
                    end else begin
                        state_r <= S_A;
                    end
                end
                S_B: begin
                    busy <= 1'b1;
                    if (in_hs_s && err_r) begin
                        // Illegal opcode: report straight away, ALU untouched.
                        in_ready  <= 1'b0;
                        out_data  <= '0;
                        out_carry <= 1'b0;
                        out_err   <= 1'b1;
                        out_valid <= 1'b1;
                        state_r   <= S_RES;
                    end else if (in_hs_s) begin
                        in_ready <= 1'b0;
                        fs       <= op_r;
                        alu_a    <= a_r;
                        alu_b    <= in_data;
                        state_r  <= S_EX;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                S_EX: begin
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                    if (cnt_zero_s) begin
                        out_data  <= alu_y;
                        out_carry <= alu_c;
                        out_err   <= 1'b0;
                        out_valid <= 1'b1;
                        state_r   <= S_RES;
`ifdef ACCUM_EN
                        last_r    <= alu_y;
`endif
                    end else begin
                        state_r <= S_EX;
                    end
                end
                S_RES: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= S_OP;
                    end else begin
                        out_valid <= 1'b1;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= S_OP;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: runs two issuers (ALU_LAT=1 and ALU_LAT=3) off one
// loader bus, each with its own ALU model, and compares every result with an
// arithmetic reference model. The latency-3 ALU model only returns a correct
// value in the third execute cycle, so early or late capture is visible.
module tb_alu_cmd_issuer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    logic       in_ready1, out_valid1, out_carry1, out_err1, busy1, alu_c1;
    logic [2:0] fs1;
    logic [7:0] alu_a1, alu_b1, alu_y1, out_data1;
    logic       in_ready3, out_valid3, out_carry3, out_err3, busy3, alu_c3;
    logic [2:0] fs3;
    logic [7:0] alu_a3, alu_b3, alu_y3, out_data3;

    int compared   = 0;
    int mismatched = 0;
    int ex3_cnt    = 0;
    logic fs_bad   = 1'b0;
    logic [7:0] last_y = 8'h00;

    always #5 clk = ~clk;

    alu_cmd_issuer #(.W(8), .ALU_LAT(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .fs(fs1), .alu_a(alu_a1), .alu_b(alu_b1),
        .alu_y(alu_y1), .alu_c(alu_c1), .out_valid(out_valid1),
        .out_ready(out_ready), .out_data(out_data1), .out_carry(out_carry1),
        .out_err(out_err1), .busy(busy1));

    alu_cmd_issuer #(.W(8), .ALU_LAT(3)) u3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3),
        .in_data(in_data), .fs(fs3), .alu_a(alu_a3), .alu_b(alu_b3),
        .alu_y(alu_y3), .alu_c(alu_c3), .out_valid(out_valid3),
        .out_ready(out_ready), .out_data(out_data3), .out_carry(out_carry3),
        .out_err(out_err3), .busy(busy3));

    // Bit-level ALU datapath model: {carry, result}; shifts are by one.
    function automatic logic [8:0] alu_f(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
        case (f)
            3'b000:  return {1'b0, a} + {1'b0, b};
            3'b001:  return {1'b0, a} - {1'b0, b};
            3'b010:  return {a[0], a[7], a[7:1]};
            3'b011:  return {a[0], 1'b0, a[7:1]};
            3'b100:  return {a[7], a[6:0], 1'b0};
            3'b101:  return {1'b0, a & b};
            3'b110:  return {1'b0, a | b};
            default: return 9'h000;
        endcase
    endfunction

    assign {alu_c1, alu_y1} = alu_f(fs1, alu_a1, alu_b1);
    assign {alu_c3, alu_y3} = (ex3_cnt == 2) ? alu_f(fs3, alu_a3, alu_b3)
                                             : ~alu_f(fs3, alu_a3, alu_b3);

    // Counts cycles u3 has spent executing (busy, no ready, no result).
    always @(posedge clk) begin
        if (busy3 && !in_ready3 && !out_valid3) ex3_cnt <= ex3_cnt + 1;
        else ex3_cnt <= 0;
    end

    // Sticky flag: fs must never carry the reserved code.
    always @(negedge clk) begin
        if (fs1 == 3'b111 || fs3 == 3'b111) fs_bad <= 1'b1;
    end

    // Reference model from the operation definitions: {err, carry, result}.
    function automatic logic [9:0] ref_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int ai, bi, r;
        logic c, e;
        ai = int'(a); bi = int'(b); r = 0; c = 1'b0; e = 1'b0;
        case (op)
            3'd0: begin r = ai + bi; c = (r > 255); r = r % 256; end
            3'd1: begin c = (ai < bi); r = (ai - bi + 256) % 256; end
            3'd2: begin c = (ai % 2 == 1); r = ai / 2 + ((ai >= 128) ? 128 : 0); end
            3'd3: begin c = (ai % 2 == 1); r = ai / 2; end
            3'd4: begin c = (ai >= 128); r = (ai * 2) % 256; end
            3'd5: r = int'(a & b);
            3'd6: r = int'(a | b);
            default: e = 1'b1;
        endcase
        return {e, c, r[7:0]};
    endfunction

    task automatic send_beat(input logic [7:0] d, input int gap_max);
        int waited;
        repeat ($urandom_range(0, gap_max)) @(negedge clk);
        waited = 0;
        @(negedge clk);
        while (!(in_ready1 && in_ready3) && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        compared++;
        if (waited >= 64) begin
            mismatched++;
            $display("FAIL beat_ready: in_ready1=%b in_ready3=%b, required 1 within 64 cycles", in_ready1, in_ready3);
        end
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] hi, input logic b7, input int gap_max, input int stall);
        logic       chain;
        logic [7:0] ea;
        logic [9:0] exp_v;
        int k1, k3, e1, e3;
`ifdef ACCUM_EN
        chain = b7;
`else
        chain = 1'b0;
`endif
        ea    = chain ? last_y : a;
        exp_v = ref_model(op, ea, b);
        out_ready = 1'b0;
        send_beat({b7, hi, op}, gap_max);
        if (!chain) send_beat(a, gap_max);
        send_beat(b, gap_max);
        k1 = 0; k3 = 0;
        for (int k = 1; k <= 20 && (k1 == 0 || k3 == 0); k++) begin
            @(negedge clk);
            if (busy1 && !in_ready1 && !out_valid1) begin
                compared++;
                if ({fs1, alu_a1, alu_b1} !== {op, ea, b}) begin
                    mismatched++;
                    $display("FAIL ex_drive1: fs/a/b=%h/%h/%h required %h/%h/%h", fs1, alu_a1, alu_b1, op, ea, b);
                end
            end
            if (busy3 && !in_ready3 && !out_valid3) begin
                compared++;
                if ({fs3, alu_a3, alu_b3} !== {op, ea, b}) begin
                    mismatched++;
                    $display("FAIL ex_drive3: fs/a/b=%h/%h/%h required %h/%h/%h", fs3, alu_a3, alu_b3, op, ea, b);
                end
            end
            if (out_valid1 && k1 == 0) k1 = k;
            if (out_valid3 && k3 == 0) k3 = k;
        end
        e1 = exp_v[9] ? 1 : 2;
        e3 = exp_v[9] ? 1 : 4;
        compared++;
        if (k1 != e1 || k3 != e3) begin
            mismatched++;
            $display("FAIL latency: lat1=%0d lat3=%0d cycles, required %0d and %0d", k1, k3, e1, e3);
        end
        for (int s = 0; s <= stall; s++) begin
            compared++;
            if ({out_valid1, in_ready1, out_err1, out_carry1, out_data1} !== {2'b10, exp_v} ||
                {out_valid3, in_ready3, out_err3, out_carry3, out_data3} !== {2'b10, exp_v}) begin
                mismatched++;
                $display("FAIL result op=%0d a=%h b=%h: dut1 v/r/e/c/y=%b%b%b%b/%h dut3=%b%b%b%b/%h required 10%b%b/%h",
                         op, ea, b, out_valid1, in_ready1, out_err1, out_carry1, out_data1,
                         out_valid3, in_ready3, out_err3, out_carry3, out_data3, exp_v[9], exp_v[8], exp_v[7:0]);
            end
            if (s < stall) @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        compared++;
        if ({out_valid1, out_valid3, busy1, busy3} !== 4'b0000) begin
            mismatched++;
            $display("FAIL release: valid1/valid3/busy1/busy3=%b%b%b%b required 0000", out_valid1, out_valid3, busy1, busy3);
        end
        if (!exp_v[9]) last_y = exp_v[7:0];
    endtask

    task automatic check_reset_outputs(input string name);
        compared++;
        if ({fs1, alu_a1, alu_b1, in_ready1, out_valid1, out_data1, out_carry1, out_err1, busy1} !== 31'd0 ||
            {fs3, alu_a3, alu_b3, in_ready3, out_valid3, out_data3, out_carry3, out_err3, busy3} !== 31'd0) begin
            mismatched++;
            $display("FAIL %s: dut1 fs=%h a=%h b=%h rdy=%b v=%b y=%h c=%b e=%b busy=%b, required all zero",
                     name, fs1, alu_a1, alu_b1, in_ready1, out_valid1, out_data1, out_carry1, out_err1, busy1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        rst = 1'b0;
        last_y = 8'h00;
        repeat (2) @(negedge clk);
        compared++;
        if (!(in_ready1 && in_ready3 && !busy1 && !busy3)) begin
            mismatched++;
            $display("FAIL idle_after_reset: rdy1=%b rdy3=%b busy1=%b busy3=%b required 1100", in_ready1, in_ready3, busy1, busy3);
        end
    endtask

    task automatic test_add();
        run_cmd(3'b000, 8'h7F, 8'h01, 4'h0, 1'b0, 0, 0);
    endtask

    task automatic test_sub_stall();
        run_cmd(3'b001, 8'h05, 8'h07, 4'h0, 1'b0, 0, 5);
    endtask

    task automatic test_illegal();
        run_cmd(3'b111, 8'($urandom), 8'($urandom), 4'h0, 1'b0, 1, 2);
        run_cmd(3'b100, 8'h81, 8'($urandom), 4'h0, 1'b0, 0, 0);
        compared++;
        if (fs_bad !== 1'b0) begin
            mismatched++;
            $display("FAIL fs_never_111: seen=%b required 0", fs_bad);
        end
    endtask

    task automatic test_reset_midcmd();
        send_beat(8'h00, 0);
        send_beat(8'h55, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 check_reset_outputs("midcmd_reset");
        rst = 1'b0;
        last_y = 8'h00;
        run_cmd(3'b101, 8'hF0, 8'h3C, 4'h0, 1'b0, 0, 0);
    endtask

    task automatic test_random_gaps();
        for (int i = 0; i < 12; i++) begin
            run_cmd(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 4'($urandom),
                    1'($urandom), 3, $urandom_range(0, 2));
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            run_cmd(3'($urandom_range(0, 6)), 8'($urandom), 8'($urandom), 4'($urandom), 1'b0, 0, 0);
        end
    endtask

`ifdef ACCUM_EN
    task automatic test_accum();
        run_cmd(3'b110, 8'h0F, 8'h30, 4'h0, 1'b0, 0, 0);
        run_cmd(3'b101, 8'h00, 8'hF1, 4'h0, 1'b1, 0, 0);
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_sub_stall();
        test_illegal();
        test_reset_midcmd();
        test_random_gaps();
        test_back_to_back();
`ifdef ACCUM_EN
        test_accum();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
